writeback_regfile: RTL and testbench

//  Consumer end of the MEM/WB interface: takes regWriteW/regAddr3W/regDin3W and commits them to the

---
 rtl/writeback_regfile_if.sv | 44 ++++
 rtl/writeback_regfile.sv | 105 ++++++++++
 tb/tb_writeback_regfile.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_regfile_if.sv
// Bundles the writeback, read and issue signals of the register file.
// The master side is the pipeline (MEM/WB and decode); the slave side is the register file.
interface writeback_regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int RF_WIDTH   = 5,
    parameter int MAX_PEND   = 4
);
    localparam int CNT_W = $clog2(MAX_PEND + 1);

    logic                  regWriteW;
    logic [RF_WIDTH-1:0]   regAddr3W;
    logic [DATA_WIDTH-1:0] regDin3W;
    logic                  wbLongW;

    logic [RF_WIDTH-1:0]   regAddr1D;
    logic [RF_WIDTH-1:0]   regAddr2D;
    logic [DATA_WIDTH-1:0] regDout1D;
    logic [DATA_WIDTH-1:0] regDout2D;
    logic                  hazard1D;
    logic                  hazard2D;

    logic                  issueValid;
    logic [RF_WIDTH-1:0]   issueRd;
    logic                  issueReady;

    logic [CNT_W-1:0]      pendCount;
    logic                  sbErr;

    modport master (
        output regWriteW, regAddr3W, regDin3W, wbLongW,
        output regAddr1D, regAddr2D,
        output issueValid, issueRd,
        input  regDout1D, regDout2D, hazard1D, hazard2D,
        input  issueReady, pendCount, sbErr
    );

    modport slave (
        input  regWriteW, regAddr3W, regDin3W, wbLongW,
        input  regAddr1D, regAddr2D,
        input  issueValid, issueRd,
        output regDout1D, regDout2D, hazard1D, hazard2D,
        output issueReady, pendCount, sbErr
    );
endinterface

// File: rtl/writeback_regfile.sv
// Architectural register file with a busy scoreboard for out-of-order long-latency writebacks.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module writeback_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int RF_WIDTH   = 5,
    parameter int MAX_PEND   = 4
) (
    input logic               clk,
    input logic               rst_n,
    writeback_regfile_if.slave rf
);
    localparam int NREGS = 2 ** RF_WIDTH;
    localparam int CNT_W = $clog2(MAX_PEND + 1);

    logic [DATA_WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0]      busy;
    logic [NREGS-1:0]      busy_nxt;
    logic [CNT_W-1:0]      pend_count;
    logic [CNT_W-1:0]      pend_nxt;
    logic                  sb_err;

    logic wr_en;
    logic cpl_en;
    logic cpl_hit;
    logic issue_ready;
    logic iss_en;

    assign wr_en   = rf.regWriteW && (rf.regAddr3W != '0);
    assign cpl_en  = wr_en && rf.wbLongW;
    assign cpl_hit = cpl_en && busy[rf.regAddr3W];

    // A completion in this same cycle never frees its register for a new issue.
    always_comb begin
        issue_ready = !(rf.issueValid && (rf.issueRd != '0) &&
                        (busy[rf.issueRd] || (pend_count == CNT_W'(MAX_PEND))));
    end

    assign iss_en = rf.issueValid && issue_ready && (rf.issueRd != '0);

    // NOTE: every variable driven in always_comb is given a default first so no latch is inferred.
    always_comb begin
        busy_nxt = busy;
        if (cpl_hit) busy_nxt[rf.regAddr3W] = 1'b0;
        if (iss_en)  busy_nxt[rf.issueRd]   = 1'b1;
    end

    always_comb begin
        pend_nxt = pend_count;
        unique case ({iss_en, cpl_hit})
            2'b10:   pend_nxt = pend_count + CNT_W'(1);
            2'b01:   pend_nxt = pend_count - CNT_W'(1);
            default: pend_nxt = pend_count;
        endcase
    end

    // NOTE: the register array is reset explicitly because reads after reset must return 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            regs[rf.regAddr3W] <= rf.regDin3W;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            pend_count <= '0;
            sb_err     <= 1'b0;
        end else begin
            busy       <= busy_nxt;
            pend_count <= pend_nxt;
            if (cpl_en && !busy[rf.regAddr3W]) sb_err <= 1'b1;
        end
    end

    always_comb begin
        rf.regDout1D = '0;
        if (rf.regAddr1D != '0) begin
            rf.regDout1D = regs[rf.regAddr1D];
`ifdef REGFILE_BYPASS_EN
            if (rf.regWriteW && (rf.regAddr3W == rf.regAddr1D)) rf.regDout1D = rf.regDin3W;
`else
            // Without forwarding, a same-cycle write becomes visible after the clock edge.
`endif
        end
    end

    always_comb begin
        rf.regDout2D = '0;
        if (rf.regAddr2D != '0) begin
            rf.regDout2D = regs[rf.regAddr2D];
`ifdef REGFILE_BYPASS_EN
            if (rf.regWriteW && (rf.regAddr3W == rf.regAddr2D)) rf.regDout2D = rf.regDin3W;
`endif
        end
    end

    assign rf.hazard1D   = busy[rf.regAddr1D] && (rf.regAddr1D != '0);
    assign rf.hazard2D   = busy[rf.regAddr2D] && (rf.regAddr2D != '0);
    assign rf.issueReady = issue_ready;
    assign rf.pendCount  = pend_count;
    assign rf.sbErr      = sb_err;
endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboarded bench for writeback_regfile: directed scenarios followed by random traffic,
// checked against an array-based reference model of the register file and its busy scoreboard.
module tb_writeback_regfile;
    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int MAX_PEND = 4;
    localparam int NREGS    = 32;

    logic clk;
    logic rst_n;

    writeback_regfile_if #(.DATA_WIDTH(DW), .RF_WIDTH(AW), .MAX_PEND(MAX_PEND)) bus ();

    writeback_regfile #(.DATA_WIDTH(DW), .RF_WIDTH(AW), .MAX_PEND(MAX_PEND)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        bit            h1;
        bit            h2;
        bit            rdy;
        int            pend;
        bit            err;
        int            tag;
    } exp_t;

    exp_t exp_q[$];

    logic [DW-1:0] m_regs [NREGS];
    bit            m_busy [NREGS];
    int            m_pend;
    bit            m_err;

    int checks   = 0;
    int failures = 0;
    int tag_cnt  = 0;
    bit stim_done = 1'b0;

    task automatic check(input string name, input int tag, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (item %0d): got %h, expected %h", name, tag, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_pend = 0;
        m_err  = 1'b0;
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input bit we,
                                                 input logic [AW-1:0] wa, input logic [DW-1:0] din);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && wa == a) return din;
`endif
        return m_regs[a];
    endfunction

    function automatic int busy_total();
        int n = 0;
        for (int i = 0; i < NREGS; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    function automatic logic [AW-1:0] pick_busy();
        int start = $urandom_range(NREGS - 1);
        for (int k = 0; k < NREGS; k++) begin
            int idx = (start + k) % NREGS;
            if (m_busy[idx]) return AW'(idx);
        end
        return AW'($urandom_range(NREGS - 1));
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(3) == 0) return AW'($urandom_range(NREGS - 1));
        return AW'($urandom_range(11));
    endfunction

    // One clock cycle of stimulus: drive, predict outputs from the pre-edge model, then advance model.
    task automatic cycle(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] din,
                         input bit wl, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input bit iv, input logic [AW-1:0] ir);
        exp_t e;
        bit   ready;
        @(posedge clk);
        #1;
        bus.regWriteW  = we;
        bus.regAddr3W  = wa;
        bus.regDin3W   = din;
        bus.wbLongW    = wl;
        bus.regAddr1D  = a1;
        bus.regAddr2D  = a2;
        bus.issueValid = iv;
        bus.issueRd    = ir;

        ready  = !(iv && ir != 0 && (m_busy[ir] || m_pend == MAX_PEND));
        e.d1   = model_read(a1, we, wa, din);
        e.d2   = model_read(a2, we, wa, din);
        e.h1   = (a1 != 0) && m_busy[a1];
        e.h2   = (a2 != 0) && m_busy[a2];
        e.rdy  = ready;
        e.pend = m_pend;
        e.err  = m_err;
        e.tag  = tag_cnt++;
        exp_q.push_back(e);

        if (we && wa != 0) begin
            m_regs[wa] = din;
            if (wl) begin
                if (m_busy[wa]) begin
                    m_busy[wa] = 1'b0;
                    m_pend--;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        if (iv && ready && ir != 0) begin
            m_busy[ir] = 1'b1;
            m_pend++;
        end
    endtask

    task automatic idle_inputs();
        bus.regWriteW  = 1'b0;
        bus.regAddr3W  = '0;
        bus.regDin3W   = '0;
        bus.wbLongW    = 1'b0;
        bus.regAddr1D  = '0;
        bus.regAddr2D  = '0;
        bus.issueValid = 1'b0;
        bus.issueRd    = '0;
    endtask

    // Reset asserted between clock edges; the monitor sees the outputs before any edge occurs.
    task automatic do_reset(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        exp_t e;
        @(posedge clk);
        #1;
        idle_inputs();
        bus.regAddr1D = a1;
        bus.regAddr2D = a2;
        rst_n = 1'b0;
        model_reset();
        e.d1 = '0; e.d2 = '0; e.h1 = 0; e.h2 = 0; e.rdy = 1; e.pend = 0; e.err = 0;
        e.tag = tag_cnt++;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("regDout1D",  e.tag, bus.regDout1D, e.d1);
            check("regDout2D",  e.tag, bus.regDout2D, e.d2);
            check("hazard1D",   e.tag, DW'(bus.hazard1D), DW'(e.h1));
            check("hazard2D",   e.tag, DW'(bus.hazard2D), DW'(e.h2));
            check("issueReady", e.tag, DW'(bus.issueReady), DW'(e.rdy));
            check("pendCount",  e.tag, DW'(bus.pendCount), DW'(e.pend));
            check("sbErr",      e.tag, DW'(bus.sbErr), DW'(e.err));
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL timeout: got no end of stimulus, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        do_reset(5'd5, 5'd0);

        // Basic write then read; x0 stays zero.
        cycle(1, 5'd5, 32'hDEADBEEF, 0, 5'd5, 5'd0, 0, 5'd0);
        cycle(0, 5'd0, 32'h0,        0, 5'd5, 5'd0, 0, 5'd0);
        cycle(1, 5'd0, 32'h1234,     0, 5'd0, 5'd5, 0, 5'd0);
        cycle(0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 0, 5'd0);
        // Same-cycle write and read of x7.
        cycle(1, 5'd7, 32'hA5A5A5A5, 0, 5'd7, 5'd7, 0, 5'd0);
        cycle(0, 5'd0, 32'h0,        0, 5'd7, 5'd0, 0, 5'd0);

        // Fill the scoreboard, then try a fifth issue and a re-issue of a busy register.
        cycle(0, 5'd0, 32'h0, 0, 5'd3, 5'd0, 1, 5'd3);
        cycle(0, 5'd0, 32'h0, 0, 5'd3, 5'd4, 1, 5'd4);
        cycle(0, 5'd0, 32'h0, 0, 5'd4, 5'd5, 1, 5'd5);
        cycle(0, 5'd0, 32'h0, 0, 5'd5, 5'd6, 1, 5'd6);
        cycle(0, 5'd0, 32'h0, 0, 5'd3, 5'd8, 1, 5'd8);
        cycle(0, 5'd0, 32'h0, 0, 5'd3, 5'd6, 1, 5'd3);
        cycle(0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 1, 5'd0);
        // Completion and issue together, both when full and with one slot free.
        cycle(1, 5'd3, 32'h33, 1, 5'd3, 5'd8, 1, 5'd8);
        cycle(1, 5'd4, 32'h44, 1, 5'd4, 5'd8, 1, 5'd8);
        cycle(1, 5'd5, 32'h55, 1, 5'd5, 5'd9, 1, 5'd9);
        cycle(0, 5'd0, 32'h0,  0, 5'd8, 5'd9, 0, 5'd0);
        // Completion on an idle register sets the sticky error and still writes data.
        cycle(1, 5'd9, 32'h99, 1, 5'd9, 5'd10, 0, 5'd0);
        cycle(1, 5'd11, 32'hBB, 1, 5'd9, 5'd11, 0, 5'd0);
        cycle(0, 5'd0, 32'h0,  0, 5'd9, 5'd6, 0, 5'd0);
        do_reset(5'd6, 5'd8);
        cycle(0, 5'd0, 32'h0,  0, 5'd9, 5'd5, 0, 5'd0);

        for (int n = 0; n < 2000; n++) begin
            bit            we, wl, iv;
            logic [AW-1:0] wa, a1, a2, ir;
            logic [DW-1:0] din;
            if ($urandom_range(249) == 0) begin
                do_reset(rand_addr(), rand_addr());
                continue;
            end
            we  = ($urandom_range(99) < 60);
            wl  = we && ($urandom_range(99) < 50);
            wa  = (wl && busy_total() > 0 && $urandom_range(99) < 80) ? pick_busy() : rand_addr();
            din = $urandom;
            iv  = ($urandom_range(99) < 45);
            ir  = rand_addr();
            case ($urandom_range(3))
                0: a1 = wa;
                1: a1 = pick_busy();
                2: a1 = '0;
                default: a1 = rand_addr();
            endcase
            case ($urandom_range(3))
                0: a2 = wa;
                1: a2 = ir;
                2: a2 = pick_busy();
                default: a2 = rand_addr();
            endcase
            cycle(we, wa, din, wl, a1, a2, iv, ir);
        end

        @(posedge clk);
        #1;
        idle_inputs();
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d unchecked items, expected 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
